uart_tx_frame: RTL

Parametrised, runtime-configurable UART transmitter. It is the successor to our fixed 8N1 transmitter and adds:
- runtime baud divisor
- optional even/odd parity
- 1 or 2 stop bits
- valid/ready input handshake
- one-entry holding buffer, giving gap-free back-to-back frames

It sits between the host-side byte source and the board TX pin.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx_frame.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
package uart_pkg;

    localparam int MIN_DIV = 2;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Zero-padding the payload to 9 bits leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input parity_t par);
        case (par)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

    // The reserved encoding 2'b11 behaves as no parity.
    function automatic parity_t decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: restarts on load, flags the last cycle of every bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 bit_end
);

    localparam logic [DIV_WIDTH-1:0] ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DMIN = DIV_WIDTH'(MIN_DIV);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_eff;

    assign div_eff = (div < DMIN) ? DMIN : div;
    assign bit_end = (cnt_q == div_q - ONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            div_q <= DMIN;
        end else if (load) begin
            cnt_q <= '0;
            div_q <= div_eff;
        end else if (bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + ONE;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Runtime-configurable UART transmitter with a one-entry holding buffer
// so that back-to-back frames leave no idle gap on the line.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_q, state_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic [DATA_BITS-1:0] hold_q, hold_n;
    logic [DATA_BITS-1:0] load_data;
    parity_t              par_q, par_n;
    logic                 stop2_q, stop2_n;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_n;
    logic                 stop_idx_q, stop_idx_n;
    logic                 hold_valid_q, hold_valid_n;
    logic                 tx_q, tx_n;
    logic                 done_q, done_n;
    logic                 accept, direct, load, bit_end;
    logic [8:0]           par_data;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load),
        .div     (cfg_div),
        .bit_end (bit_end)
    );

    always_comb begin
        state_n      = state_q;
        shift_n      = shift_q;
        data_n       = data_q;
        par_n        = par_q;
        stop2_n      = stop2_q;
        bit_idx_n    = bit_idx_q;
        stop_idx_n   = stop_idx_q;
        hold_n       = hold_q;
        hold_valid_n = hold_valid_q;
        done_n       = 1'b0;
        load         = 1'b0;
        direct       = 1'b0;
        load_data    = s_data;
        accept       = s_valid && !hold_valid_q;

        case (state_q)
            IDLE: if (accept) direct = 1'b1;
            START: if (bit_end) begin
                state_n   = DATA;
                bit_idx_n = '0;
            end
            DATA: if (bit_end) begin
                shift_n = shift_q >> 1;
                if (bit_idx_q == LAST_IDX) begin
                    state_n    = (par_q != PAR_NONE) ? PARITY : STOP;
                    stop_idx_n = 1'b0;
                end else begin
                    bit_idx_n = bit_idx_q + 1'b1;
                end
            end
            PARITY: if (bit_end) begin
                state_n    = STOP;
                stop_idx_n = 1'b0;
            end
            STOP: if (bit_end) begin
                if (stop2_q && !stop_idx_q) begin
                    stop_idx_n = 1'b1;
                end else begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                    if (hold_valid_q) begin
                        load         = 1'b1;
                        load_data    = hold_q;
                        hold_valid_n = 1'b0;
                    end else if (accept) begin
                        direct = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (direct) begin
            load = 1'b1;
        end else if (accept) begin
            hold_n       = s_data;
            hold_valid_n = 1'b1;
        end

        // Configuration is sampled only here, so mid-frame changes wait for the next frame.
        if (load) begin
            state_n = START;
            shift_n = load_data;
            data_n  = load_data;
            par_n   = decode_parity(cfg_parity);
            stop2_n = cfg_stop2;
        end

        par_data                = '0;
        par_data[DATA_BITS-1:0] = data_n;

        // tx is registered from the next state so the line changes on the same edge as the state.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = parity_bit(par_data, par_n);
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            data_q       <= '0;
            hold_q       <= '0;
            par_q        <= PAR_NONE;
            stop2_q      <= 1'b0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            shift_q      <= shift_n;
            data_q       <= data_n;
            hold_q       <= hold_n;
            par_q        <= par_n;
            stop2_q      <= stop2_n;
            bit_idx_q    <= bit_idx_n;
            stop_idx_q   <= stop_idx_n;
            hold_valid_q <= hold_valid_n;
            tx_q         <= tx_n;
            done_q       <= done_n;
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign s_ready = !hold_valid_q;
    assign tx_busy = (state_q != IDLE) || hold_valid_q;

endmodule
